// File: rtl/fp_operand_unpack_pkg.sv
// Shared float32 types for the FP execute front end.
// Also holds the pipeline bundle types and the operand unpack helper.
package fp_operand_unpack_pkg;

    localparam int NUM_VECTOR_LANES  = 16;
    localparam int FLOAT32_EXP_WIDTH = 8;
    localparam int FLOAT32_SIG_WIDTH = 23;
    localparam int FLOAT32_EXP_BIAS  = 127;

    typedef logic [1:0]                        local_thread_idx_t;
    typedef logic [NUM_VECTOR_LANES-1:0]       vector_mask_t;
    typedef logic [3:0]                        subcycle_t;
    typedef logic [NUM_VECTOR_LANES-1:0][31:0] vector_t;

    typedef enum logic [5:0] {
        OP_OR      = 6'h00,
        OP_ADD_F   = 6'h20,
        OP_SUB_F   = 6'h21,
        OP_MUL_F   = 6'h22,
        OP_CMPEQ_F = 6'h2c,
        OP_CMPNE_F = 6'h2d,
        OP_CMPGT_F = 6'h2e,
        OP_CMPGE_F = 6'h2f,
        OP_CMPLT_F = 6'h30,
        OP_CMPLE_F = 6'h31
    } alu_op_t;

    typedef struct packed {
        alu_op_t    alu_op;
        logic [4:0] dest_reg;
        logic       has_dest;
    } decoded_instruction_t;

    typedef struct packed {
        logic                         sign;
        logic [FLOAT32_EXP_WIDTH-1:0] exponent;
        logic [FLOAT32_SIG_WIDTH-1:0] significand;
    } float32_t;

    typedef struct packed {
        logic                         sign;
        logic [FLOAT32_EXP_WIDTH-1:0] exp;
        logic [FLOAT32_EXP_WIDTH-1:0] eff_exp;
        logic [FLOAT32_SIG_WIDTH:0]   sig;
        logic                         nan;
        logic                         inf;
        logic                         zero;
    } unpacked_t;

    typedef struct packed {
        logic                         result_inf;
        logic                         result_nan;
        logic                         equal;
        logic                         logical_subtract;
        logic                         add_result_sign;
        logic [FLOAT32_EXP_WIDTH-1:0] exp_diff;
        logic [FLOAT32_EXP_WIDTH-1:0] add_exponent;
        logic [FLOAT32_SIG_WIDTH:0]   sig_large;
        logic [FLOAT32_SIG_WIDTH:0]   sig_small;
        logic [FLOAT32_EXP_WIDTH-1:0] mul_exponent;
        logic                         mul_underflow;
        logic                         mul_sign;
    } lane_result_t;

    function automatic logic is_compare(alu_op_t op);
        return op inside {OP_CMPEQ_F, OP_CMPNE_F, OP_CMPGT_F,
                          OP_CMPGE_F, OP_CMPLT_F, OP_CMPLE_F};
    endfunction

    // Subnormals behave as exponent 1 with no hidden bit.
    function automatic unpacked_t unpack_float(float32_t f);
        unpacked_t u;
        u.sign    = f.sign;
        u.exp     = f.exponent;
        u.eff_exp = (f.exponent == '0) ? 8'd1 : f.exponent;
        u.sig     = {f.exponent != '0, f.significand};
        u.nan     = (&f.exponent) && (f.significand != '0);
        u.inf     = (&f.exponent) && (f.significand == '0);
        u.zero    = (f.exponent == '0) && (f.significand == '0);
        return u;
    endfunction

endpackage

// File: rtl/fp_operand_unpack_lane.sv
// One lane of the unpack front end: operand unpack and
// add/compare/multiply classification, purely combinational.
module fp_lane_unpack
    import fp_operand_unpack_pkg::*;
(
    input  logic [31:0]  operand1,
    input  logic [31:0]  operand2,
    output unpacked_t    unpacked1,
    output unpacked_t    unpacked2,
    input  alu_op_t      alu_op,
    input  unpacked_t    stage_a1,
    input  unpacked_t    stage_a2,
    output lane_result_t result
);

    logic              is_cmp;
    logic              eff_sign2;
    logic              lsub;
    logic              swap;
    logic              same_mag;
    logic              add_nan;
    logic              add_inf;
    logic              mul_nan;
    logic              mul_inf;
    logic        [9:0] exp_sum;
    logic signed [9:0] mul_sum;

    assign unpacked1 = unpack_float(float32_t'(operand1));
    assign unpacked2 = unpack_float(float32_t'(operand2));

    always_comb begin
        is_cmp    = is_compare(alu_op);
        eff_sign2 = stage_a2.sign ^ (is_cmp || alu_op == OP_SUB_F);
        lsub      = stage_a1.sign ^ eff_sign2;
        swap      = {stage_a2.exp, stage_a2.sig[22:0]}
                  > {stage_a1.exp, stage_a1.sig[22:0]};
        same_mag  = {stage_a2.exp, stage_a2.sig[22:0]}
                 == {stage_a1.exp, stage_a1.sig[22:0]};
        add_nan   = stage_a1.nan || stage_a2.nan
                 || (stage_a1.inf && stage_a2.inf && lsub);
        add_inf   = (stage_a1.inf || stage_a2.inf) && !add_nan;

        exp_sum   = {2'b00, stage_a1.eff_exp} + {2'b00, stage_a2.eff_exp};
        mul_sum   = $signed(exp_sum - 10'(FLOAT32_EXP_BIAS));
        mul_nan   = stage_a1.nan || stage_a2.nan
                 || (stage_a1.inf && stage_a2.zero)
                 || (stage_a2.inf && stage_a1.zero);
        mul_inf   = !mul_nan
                 && (stage_a1.inf || stage_a2.inf || mul_sum >= 10'sd255);

        result = '0;
        result.logical_subtract = lsub;
        result.equal = ({stage_a1.sign, stage_a1.exp, stage_a1.sig}
                     == {stage_a2.sign, stage_a2.exp, stage_a2.sig})
                     || (stage_a1.zero && stage_a2.zero);
        result.add_exponent = swap ? stage_a2.eff_exp : stage_a1.eff_exp;
        result.exp_diff = swap ? stage_a2.eff_exp - stage_a1.eff_exp
                               : stage_a1.eff_exp - stage_a2.eff_exp;
        // x - x is +0 for arithmetic but compares keep the first sign.
        if (same_mag && lsub)
            result.add_result_sign = is_cmp && stage_a1.sign;
        else
            result.add_result_sign = swap ? eff_sign2 : stage_a1.sign;

        result.mul_sign      = stage_a1.sign ^ stage_a2.sign;
        result.mul_underflow = !mul_nan && !mul_inf && mul_sum < 10'sd1;
        result.mul_exponent  = (mul_sum < 10'sd1) ? 8'd0 : mul_sum[7:0];

        if (alu_op == OP_MUL_F) begin
            result.result_nan = mul_nan;
            result.result_inf = mul_inf;
            result.sig_large  = stage_a1.sig;
            result.sig_small  = stage_a2.sig;
        end else begin
            result.result_nan = add_nan;
            result.result_inf = add_inf;
            result.sig_large  = swap ? stage_a2.sig : stage_a1.sig;
            result.sig_small  = swap ? stage_a1.sig : stage_a2.sig;
        end
    end

endmodule

// File: rtl/fp_operand_unpack.sv
// FP execute front end: two registered stages that unpack and
// classify float32 lanes, with per-thread rollback squash.
module fp_operand_unpack
    import fp_operand_unpack_pkg::*;
(
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                of_instruction_valid,
    input  decoded_instruction_t                of_instruction,
    input  local_thread_idx_t                   of_thread_idx,
    input  vector_mask_t                        of_mask_value,
    input  subcycle_t                           of_subcycle,
    input  vector_t                             of_operand1,
    input  vector_t                             of_operand2,
    input  logic                                rollback_en,
    input  local_thread_idx_t                   rollback_thread_idx,
    output logic                                fx1_instruction_valid,
    output decoded_instruction_t                fx1_instruction,
    output local_thread_idx_t                   fx1_thread_idx,
    output vector_mask_t                        fx1_mask_value,
    output subcycle_t                           fx1_subcycle,
    output logic [NUM_VECTOR_LANES-1:0]         fx1_result_inf,
    output logic [NUM_VECTOR_LANES-1:0]         fx1_result_nan,
    output logic [NUM_VECTOR_LANES-1:0]         fx1_equal,
    output logic [NUM_VECTOR_LANES-1:0]         fx1_logical_subtract,
    output logic [NUM_VECTOR_LANES-1:0]         fx1_add_result_sign,
    output logic [NUM_VECTOR_LANES-1:0][7:0]    fx1_exp_diff,
    output logic [NUM_VECTOR_LANES-1:0][7:0]    fx1_add_exponent,
    output logic [NUM_VECTOR_LANES-1:0][23:0]   fx1_sig_large,
    output logic [NUM_VECTOR_LANES-1:0][23:0]   fx1_sig_small,
    output logic [NUM_VECTOR_LANES-1:0][7:0]    fx1_mul_exponent,
    output logic [NUM_VECTOR_LANES-1:0]         fx1_mul_underflow,
    output logic [NUM_VECTOR_LANES-1:0]         fx1_mul_sign
);

    logic                 a_valid;
    decoded_instruction_t a_instruction;
    local_thread_idx_t    a_thread_idx;
    vector_mask_t         a_mask_value;
    subcycle_t            a_subcycle;
    unpacked_t            a_op1    [NUM_VECTOR_LANES];
    unpacked_t            a_op2    [NUM_VECTOR_LANES];
    unpacked_t            next_op1 [NUM_VECTOR_LANES];
    unpacked_t            next_op2 [NUM_VECTOR_LANES];
    lane_result_t         lane_result [NUM_VECTOR_LANES];
    logic                 kill_in;
    logic                 kill_a;

    for (genvar i = 0; i < NUM_VECTOR_LANES; i++) begin : g_lane
        fp_lane_unpack u_lane (
            .operand1  (of_operand1[i]),
            .operand2  (of_operand2[i]),
            .unpacked1 (next_op1[i]),
            .unpacked2 (next_op2[i]),
            .alu_op    (a_instruction.alu_op),
            .stage_a1  (a_op1[i]),
            .stage_a2  (a_op2[i]),
            .result    (lane_result[i])
        );
    end

    assign kill_in = rollback_en && of_thread_idx == rollback_thread_idx;
    assign kill_a  = rollback_en && a_thread_idx == rollback_thread_idx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_valid               <= 1'b0;
            fx1_instruction_valid <= 1'b0;
        end else begin
            a_valid               <= of_instruction_valid && !kill_in;
            fx1_instruction_valid <= a_valid && !kill_a;
        end
    end

    // Data registers carry no reset; valid qualifies them.
    always_ff @(posedge clk) begin
        a_instruction   <= of_instruction;
        a_thread_idx    <= of_thread_idx;
        a_mask_value    <= of_mask_value;
        a_subcycle      <= of_subcycle;
        a_op1           <= next_op1;
        a_op2           <= next_op2;
        fx1_instruction <= a_instruction;
        fx1_thread_idx  <= a_thread_idx;
        fx1_mask_value  <= a_mask_value;
        fx1_subcycle    <= a_subcycle;
        for (int i = 0; i < NUM_VECTOR_LANES; i++) begin
            fx1_result_inf[i]       <= lane_result[i].result_inf;
            fx1_result_nan[i]       <= lane_result[i].result_nan;
            fx1_equal[i]            <= lane_result[i].equal;
            fx1_logical_subtract[i] <= lane_result[i].logical_subtract;
            fx1_add_result_sign[i]  <= lane_result[i].add_result_sign;
            fx1_exp_diff[i]         <= lane_result[i].exp_diff;
            fx1_add_exponent[i]     <= lane_result[i].add_exponent;
            fx1_sig_large[i]        <= lane_result[i].sig_large;
            fx1_sig_small[i]        <= lane_result[i].sig_small;
            fx1_mul_exponent[i]     <= lane_result[i].mul_exponent;
            fx1_mul_underflow[i]    <= lane_result[i].mul_underflow;
            fx1_mul_sign[i]         <= lane_result[i].mul_sign;
        end
    end

endmodule

// File: tb/tb_fp_operand_unpack.sv
// Bench for fp_operand_unpack: directed spec cases, then random
// traffic with rollbacks checked against an arithmetic float model.
module tb_fp_operand_unpack;
    import fp_operand_unpack_pkg::*;

    localparam int L = NUM_VECTOR_LANES;

    logic                       clk = 1'b0;
    logic                       reset;
    logic                       of_instruction_valid;
    decoded_instruction_t       of_instruction;
    local_thread_idx_t          of_thread_idx;
    vector_mask_t               of_mask_value;
    subcycle_t                  of_subcycle;
    vector_t                    of_operand1;
    vector_t                    of_operand2;
    logic                       rollback_en;
    local_thread_idx_t          rollback_thread_idx;
    logic                       fx1_instruction_valid;
    decoded_instruction_t       fx1_instruction;
    local_thread_idx_t          fx1_thread_idx;
    vector_mask_t               fx1_mask_value;
    subcycle_t                  fx1_subcycle;
    logic [L-1:0]               fx1_result_inf;
    logic [L-1:0]               fx1_result_nan;
    logic [L-1:0]               fx1_equal;
    logic [L-1:0]               fx1_logical_subtract;
    logic [L-1:0]               fx1_add_result_sign;
    logic [L-1:0][7:0]          fx1_exp_diff;
    logic [L-1:0][7:0]          fx1_add_exponent;
    logic [L-1:0][23:0]         fx1_sig_large;
    logic [L-1:0][23:0]         fx1_sig_small;
    logic [L-1:0][7:0]          fx1_mul_exponent;
    logic [L-1:0]               fx1_mul_underflow;
    logic [L-1:0]               fx1_mul_sign;

    fp_operand_unpack dut (
        .clk                   (clk),
        .reset                 (reset),
        .of_instruction_valid  (of_instruction_valid),
        .of_instruction        (of_instruction),
        .of_thread_idx         (of_thread_idx),
        .of_mask_value         (of_mask_value),
        .of_subcycle           (of_subcycle),
        .of_operand1           (of_operand1),
        .of_operand2           (of_operand2),
        .rollback_en           (rollback_en),
        .rollback_thread_idx   (rollback_thread_idx),
        .fx1_instruction_valid (fx1_instruction_valid),
        .fx1_instruction       (fx1_instruction),
        .fx1_thread_idx        (fx1_thread_idx),
        .fx1_mask_value        (fx1_mask_value),
        .fx1_subcycle          (fx1_subcycle),
        .fx1_result_inf        (fx1_result_inf),
        .fx1_result_nan        (fx1_result_nan),
        .fx1_equal             (fx1_equal),
        .fx1_logical_subtract  (fx1_logical_subtract),
        .fx1_add_result_sign   (fx1_add_result_sign),
        .fx1_exp_diff          (fx1_exp_diff),
        .fx1_add_exponent      (fx1_add_exponent),
        .fx1_sig_large         (fx1_sig_large),
        .fx1_sig_small         (fx1_sig_small),
        .fx1_mul_exponent      (fx1_mul_exponent),
        .fx1_mul_underflow     (fx1_mul_underflow),
        .fx1_mul_sign          (fx1_mul_sign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic                 valid;
        decoded_instruction_t instr;
        local_thread_idx_t    thr;
        vector_mask_t         mask;
        subcycle_t            sc;
        vector_t              a;
        vector_t              b;
    } txn_t;

    typedef struct {
        bit inf, nan, eq, lsub, sgn, unf, msign;
        int ediff, aexp, sl, ss, mexp;
    } lane_exp_t;

    int   errors = 0;
    int   checks = 0;
    int   valid_seen = 0;
    txn_t pipe [2];
    txn_t idle;
    txn_t t;
    logic rb;

    alu_op_t op_list [10] = '{OP_ADD_F, OP_SUB_F, OP_MUL_F, OP_CMPEQ_F,
                              OP_CMPNE_F, OP_CMPGT_F, OP_CMPGE_F,
                              OP_CMPLT_F, OP_CMPLE_F, OP_OR};

    task automatic chk(input string tag, input int lane,
                       input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s lane %0d: observed %h expected %h",
                   tag, lane, obs, expv);
        end
    endtask

    // Float semantics from magnitudes and plain integer exponent math.
    function automatic lane_exp_t model(input alu_op_t op,
                                        input logic [31:0] x,
                                        input logic [31:0] y);
        lane_exp_t r;
        int e1, e2, ee1, ee2, m1, m2, sum;
        bit s1, s2, n1, n2, i1, i2, z1, z2, cmp, es2, big2;
        r = '{default: 0};
        s1 = x[31];
        s2 = y[31];
        e1 = int'(x[30:23]);
        e2 = int'(y[30:23]);
        ee1 = (e1 == 0) ? 1 : e1;
        ee2 = (e2 == 0) ? 1 : e2;
        m1 = ((e1 == 0) ? 0 : 32'h800000) + int'(x[22:0]);
        m2 = ((e2 == 0) ? 0 : 32'h800000) + int'(y[22:0]);
        n1 = (e1 == 255) && (x[22:0] != 0);
        n2 = (e2 == 255) && (y[22:0] != 0);
        i1 = (e1 == 255) && (x[22:0] == 0);
        i2 = (e2 == 255) && (y[22:0] == 0);
        z1 = (x[30:0] == 0);
        z2 = (y[30:0] == 0);
        cmp = op inside {OP_CMPEQ_F, OP_CMPNE_F, OP_CMPGT_F,
                         OP_CMPGE_F, OP_CMPLT_F, OP_CMPLE_F};
        if (op == OP_MUL_F) begin
            sum     = ee1 + ee2 - 127;
            r.msign = s1 ^ s2;
            r.nan   = n1 || n2 || (i1 && z2) || (i2 && z1);
            r.inf   = !r.nan && (i1 || i2 || sum >= 255);
            r.unf   = !r.nan && !r.inf && sum < 1;
            r.mexp  = (sum < 1) ? 0 : sum;
            r.sl    = m1;
            r.ss    = m2;
        end else begin
            es2    = s2 ^ (op == OP_SUB_F || cmp);
            big2   = y[30:0] > x[30:0];
            r.lsub = s1 ^ es2;
            r.aexp = big2 ? ee2 : ee1;
            r.ediff = big2 ? ee2 - ee1 : ee1 - ee2;
            r.sl   = big2 ? m2 : m1;
            r.ss   = big2 ? m1 : m2;
            if (x[30:0] == y[30:0] && r.lsub)
                r.sgn = cmp ? s1 : 1'b0;
            else
                r.sgn = big2 ? es2 : s1;
            r.eq   = (x == y) || (z1 && z2);
            r.nan  = n1 || n2 || (i1 && i2 && r.lsub);
            r.inf  = (i1 || i2) && !r.nan;
        end
        return r;
    endfunction

    task automatic check_out(input txn_t e);
        lane_exp_t m;
        alu_op_t   op;
        chk("valid", 0, 32'(fx1_instruction_valid), 32'(e.valid));
        if (fx1_instruction_valid === 1'b1) valid_seen++;
        if (e.valid) begin
            op = e.instr.alu_op;
            chk("instr", 0, 32'(fx1_instruction), 32'(e.instr));
            chk("thread", 0, 32'(fx1_thread_idx), 32'(e.thr));
            chk("mask", 0, 32'(fx1_mask_value), 32'(e.mask));
            chk("subcycle", 0, 32'(fx1_subcycle), 32'(e.sc));
            for (int i = 0; i < L; i++) begin
                m = model(op, e.a[i], e.b[i]);
                if (op == OP_OR) continue;
                chk("result_inf", i, 32'(fx1_result_inf[i]), 32'(m.inf));
                chk("result_nan", i, 32'(fx1_result_nan[i]), 32'(m.nan));
                chk("sig_large", i, 32'(fx1_sig_large[i]), m.sl);
                chk("sig_small", i, 32'(fx1_sig_small[i]), m.ss);
                if (op == OP_MUL_F) begin
                    chk("mul_sign", i, 32'(fx1_mul_sign[i]), 32'(m.msign));
                    chk("mul_uflow", i,
                        32'(fx1_mul_underflow[i]), 32'(m.unf));
                    if (!m.nan && !m.inf)
                        chk("mul_exp", i, 32'(fx1_mul_exponent[i]), m.mexp);
                end else begin
                    chk("equal", i, 32'(fx1_equal[i]), 32'(m.eq));
                    chk("lsub", i, 32'(fx1_logical_subtract[i]),
                        32'(m.lsub));
                    chk("add_sign", i, 32'(fx1_add_result_sign[i]),
                        32'(m.sgn));
                    chk("exp_diff", i, 32'(fx1_exp_diff[i]), m.ediff);
                    chk("add_exp", i, 32'(fx1_add_exponent[i]), m.aexp);
                end
            end
        end
    endtask

    // One clock: drive at negedge, update the model at posedge,
    // compare at the following negedge.
    task automatic cycle(input txn_t x, input logic rbk,
                         input local_thread_idx_t rbt);
        of_instruction_valid = x.valid;
        of_instruction       = x.instr;
        of_thread_idx        = x.thr;
        of_mask_value        = x.mask;
        of_subcycle          = x.sc;
        of_operand1          = x.a;
        of_operand2          = x.b;
        rollback_en          = rbk;
        rollback_thread_idx  = rbt;
        @(posedge clk);
        if (!reset) begin
            pipe[0].valid = 1'b0;
            pipe[1].valid = 1'b0;
        end else begin
            for (int k = 0; k < 2; k++)
                if (rbk && pipe[k].thr == rbt) pipe[k].valid = 1'b0;
            if (rbk && x.thr == rbt) x.valid = 1'b0;
            pipe[0] = pipe[1];
            pipe[1] = x;
        end
        @(negedge clk);
        check_out(pipe[0]);
    endtask

    function automatic txn_t mk(input alu_op_t op, input int thr,
                                input logic [31:0] x,
                                input logic [31:0] y);
        txn_t r;
        r.valid           = 1'b1;
        r.instr.alu_op    = op;
        r.instr.dest_reg  = 5'($urandom);
        r.instr.has_dest  = 1'($urandom);
        r.thr             = local_thread_idx_t'(thr);
        r.mask            = vector_mask_t'($urandom);
        r.sc              = subcycle_t'($urandom);
        for (int i = 0; i < L; i++) begin
            r.a[i] = x;
            r.b[i] = y;
        end
        return r;
    endfunction

    function automatic logic [31:0] rand_float();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 9))
            0: r = {r[31], 31'h0};
            1: r = {r[31], 8'hFF, 23'h0};
            2: r = {r[31], 8'hFF, r[22:1], 1'b1};
            3: r = {r[31], 8'h00, r[22:0]};
            4: r = {r[31], 6'b011111, r[24:0]};
            5: r = {r[31], 2'b11, r[28:0]};
            6: r = {r[31], 3'b000, r[27:0]};
            default: r = r;
        endcase
        return r;
    endfunction

    task automatic run1(input txn_t x);
        cycle(x, 1'b0, 2'd0);
        cycle(idle, 1'b0, 2'd0);
    endtask

    initial begin
        idle = mk(OP_ADD_F, 0, 32'h0, 32'h0);
        idle.valid = 1'b0;
        pipe[0] = idle;
        pipe[1] = idle;
        reset = 1'b0;
        of_instruction_valid = 1'b0;
        of_instruction = '0;
        of_thread_idx = '0;
        of_mask_value = '0;
        of_subcycle = '0;
        of_operand1 = '0;
        of_operand2 = '0;
        rollback_en = 1'b0;
        rollback_thread_idx = '0;
        #1;
        chk("reset_valid", 0, 32'(fx1_instruction_valid), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        run1(mk(OP_ADD_F, 1, 32'h3F800000, 32'h40000000));
        chk("add_exp_diff", 0, 32'(fx1_exp_diff[0]), 32'd1);
        chk("add_exponent", 0, 32'(fx1_add_exponent[0]), 32'h80);
        chk("add_sig_large", 0, 32'(fx1_sig_large[0]), 32'h800000);
        chk("add_sig_small", 0, 32'(fx1_sig_small[0]), 32'h800000);
        chk("add_lsub", 0, 32'(fx1_logical_subtract[0]), 32'd0);

        run1(mk(OP_SUB_F, 2, 32'h40400000, 32'h40400000));
        chk("sub_lsub", 0, 32'(fx1_logical_subtract[0]), 32'd1);
        chk("sub_equal", 0, 32'(fx1_equal[0]), 32'd1);
        chk("sub_sign", 0, 32'(fx1_add_result_sign[0]), 32'd0);

        run1(mk(OP_CMPEQ_F, 3, 32'h80000000, 32'h00000000));
        chk("cmp_zero_eq", 0, 32'(fx1_equal[0]), 32'd1);

        run1(mk(OP_SUB_F, 0, 32'h7F800000, 32'h7F800000));
        chk("inf_inf_nan", 0, 32'(fx1_result_nan[0]), 32'd1);
        chk("inf_inf_inf", 0, 32'(fx1_result_inf[0]), 32'd0);

        run1(mk(OP_ADD_F, 0, 32'h7FC00000, 32'h3F800000));
        chk("qnan_add", 0, 32'(fx1_result_nan[0]), 32'd1);

        run1(mk(OP_MUL_F, 1, 32'h7F000000, 32'h40000000));
        chk("mul_ovf_inf", 0, 32'(fx1_result_inf[0]), 32'd1);
        run1(mk(OP_MUL_F, 1, 32'h00800000, 32'h00800000));
        chk("mul_uflow", 0, 32'(fx1_mul_underflow[0]), 32'd1);
        run1(mk(OP_MUL_F, 1, 32'h7F800000, 32'h00000000));
        chk("mul_inf_zero", 0, 32'(fx1_result_nan[0]), 32'd1);

        valid_seen = 0;
        cycle(mk(OP_ADD_F, 1, 32'h3F800000, 32'h3F800000), 1'b0, 2'd0);
        cycle(mk(OP_ADD_F, 2, 32'h40000000, 32'h3F800000), 1'b0, 2'd0);
        cycle(mk(OP_ADD_F, 2, 32'h40400000, 32'h3F800000), 1'b1, 2'd2);
        cycle(idle, 1'b0, 2'd0);
        cycle(idle, 1'b0, 2'd0);
        chk("rollback_count", 0, 32'(valid_seen), 32'd1);

        cycle(mk(OP_ADD_F, 0, 32'h3F800000, 32'h40000000), 1'b0, 2'd0);
        cycle(mk(OP_SUB_F, 1, 32'h40000000, 32'h3F800000), 1'b0, 2'd0);
        #2;
        reset = 1'b0;
        pipe[0].valid = 1'b0;
        pipe[1].valid = 1'b0;
        #1;
        chk("reset_async", 0, 32'(fx1_instruction_valid), 32'd0);
        cycle(mk(OP_MUL_F, 3, 32'h40000000, 32'h40000000), 1'b0, 2'd0);
        reset = 1'b1;
        cycle(idle, 1'b0, 2'd0);
        cycle(idle, 1'b0, 2'd0);
        cycle(mk(OP_ADD_F, 2, 32'h41000000, 32'h3F800000), 1'b0, 2'd0);
        chk("post_reset_gap", 0, 32'(fx1_instruction_valid), 32'd0);
        cycle(idle, 1'b0, 2'd0);
        chk("post_reset_lat", 0, 32'(fx1_instruction_valid), 32'd1);

        for (int n = 0; n < 300; n++) begin
            t = mk(op_list[$urandom_range(0, 9)],
                   int'($urandom_range(0, 3)), 32'h0, 32'h0);
            for (int i = 0; i < L; i++) begin
                t.a[i] = rand_float();
                if ($urandom_range(0, 7) == 0)
                    t.b[i] = t.a[i] ^ ($urandom & 32'h80000000);
                else
                    t.b[i] = rand_float();
            end
            t.valid = ($urandom_range(0, 4) != 0);
            rb = ($urandom_range(0, 5) == 0);
            cycle(t, rb, local_thread_idx_t'($urandom_range(0, 3)));
        end
        repeat (3) cycle(idle, 1'b0, 2'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
